axil_reg_slave: RTL and testbench



---
 rtl/axil_reg_slave.sv | 164 ++++++++++++++++
 tb/tb_axil_reg_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// axil_reg_slave
// AXI-Lite responder for the NPU host control port. Implements NUM_REGS
// word-aligned 32-bit registers; each is either read/write control (driving
// reg_out) or read-only status (returning status_in), selected by RO_MASK.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*               AXI-Lite write address / data / response
//   s_ar*/s_r*                    AXI-Lite read address / data
//   reg_out   [NUM_REGS*32]       R/W register contents, reg i at [32i+31:32i]
//   status_in [NUM_REGS*32]       status values returned for RO registers
//   wr_pulse  [NUM_REGS]          one-cycle strobe on committed write to reg i
//   rd_pulse  [NUM_REGS]          one-cycle strobe on accepted read of reg i
module axil_reg_slave #(
    parameter int unsigned           NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              s_awaddr,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [31:0]              s_araddr,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    input  logic [NUM_REGS*32-1:0]   status_in,
    output logic [NUM_REGS-1:0]      wr_pulse,
    output logic [NUM_REGS-1:0]      rd_pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Cleared by reset so that every ready is low while reset is applied.
    logic              active;

    logic              aw_held;
    logic              w_held;
    logic [31:0]       aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic [31:0]       regs       [NUM_REGS];
    logic [31:0]       status_arr [NUM_REGS];

    logic [IDX_W-1:0]  wr_idx;
    logic              wr_mapped;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_mapped;

    logic              unused_addr_bits;

    assign s_awready = active && !aw_held && !s_bvalid;
    assign s_wready  = active && !w_held  && !s_bvalid;
    assign s_arready = active && !s_rvalid;

    // Low address bits are ignored by the decode.
    assign unused_addr_bits = ^{aw_addr_q[1:0], s_araddr[1:0]};

    always_comb begin
        wr_idx    = aw_addr_q[IDX_W+1:2];
        wr_mapped = (aw_addr_q[31:IDX_W+2] == '0);
        rd_idx    = s_araddr[IDX_W+1:2];
        rd_mapped = (s_araddr[31:IDX_W+2] == '0);
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs[i];
            status_arr[i]       = status_in[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active    <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
            wr_pulse  <= '0;
            rd_pulse  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            active   <= 1'b1;
            wr_pulse <= '0;
            rd_pulse <= '0;

            // Capture and commit are mutually exclusive: a capture needs the
            // holding slot empty, a commit needs both slots full.
            if (s_awvalid && s_awready) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_held   <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end

            if (aw_held && w_held) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                if (!wr_mapped) begin
                    s_bresp <= RESP_DECERR;
                end else if (RO_MASK[wr_idx]) begin
                    s_bresp <= RESP_SLVERR;
                end else begin
                    s_bresp <= RESP_OKAY;
                    wr_pulse[wr_idx] <= 1'b1;
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (w_strb_q[k]) begin
                            regs[wr_idx][8*k +: 8] <= w_data_q[8*k +: 8];
                        end
                    end
                end
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end

            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                if (!rd_mapped) begin
                    s_rdata <= '0;
                    s_rresp <= RESP_DECERR;
                end else begin
                    s_rdata  <= RO_MASK[rd_idx] ? status_arr[rd_idx] : regs[rd_idx];
                    s_rresp  <= RESP_OKAY;
                    rd_pulse[rd_idx] <= 1'b1;
                end
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Testbench for axil_reg_slave (NUM_REGS=16, register 15 read-only).
// Directed scenarios followed by randomized transactions, all checked against
// a behavioural register-file model.
module tb_axil_reg_slave;

    localparam int unsigned N = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [31:0]       s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [N*32-1:0]   reg_out;
    logic [N*32-1:0]   status_in;
    logic [N-1:0]      wr_pulse;
    logic [N-1:0]      rd_pulse;

    axil_reg_slave #(.NUM_REGS(N), .RO_MASK(16'h8000)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_out(reg_out), .status_in(status_in),
        .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: plain register file, reg 15 is status.
    logic [31:0] model_regs [N];
    logic aw_hs, w_hs, ar_hs;

    task automatic check(input string tag, input logic [N*32-1:0] got, input logic [N*32-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [N*32-1:0] model_vec();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = model_regs[i];
        return v;
    endfunction

    // Expected outcome of an access: response code and whether it targets a
    // writable / readable mapped register.
    function automatic logic [1:0] model_wresp(input logic [31:0] addr);
        if (addr >= 32'(4*N)) return 2'b11;
        if (addr[5:2] == 4'd15) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        if (addr >= 32'(4*N)) return 32'h0;
        if (addr[5:2] == 4'd15) return status_in[15*32 +: 32];
        return model_regs[addr[5:2]];
    endfunction

    function automatic logic [N-1:0] onehot_if(input logic en, input logic [31:0] addr);
        logic [N-1:0] v;
        v = '0;
        if (en) v[addr[5:2]] = 1'b1;
        return v;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (model_wresp(addr) == 2'b00)
            for (int k = 0; k < 4; k++)
                if (strb[k]) model_regs[addr[5:2]][8*k +: 8] = data[8*k +: 8];
    endtask

    task automatic step();
        aw_hs = s_awvalid && s_awready;
        w_hs  = s_wvalid && s_wready;
        ar_hs = s_arvalid && s_arready;
        @(posedge clk);
        #1;
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int bdelay);
        bit aw_done = 0, w_done = 0;
        int cyc = 0;
        int alead = (lead < 0) ? -lead : lead;
        logic [1:0] exp_resp;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        if (lead >= 0) s_wvalid = 1'b1;
        if (lead <= 0) s_awvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 50) begin
            step();
            cyc++;
            if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_wvalid  = 1'b0; end
            if (cyc == alead) begin
                if (lead > 0 && !aw_done) s_awvalid = 1'b1;
                if (lead < 0 && !w_done)  s_wvalid  = 1'b1;
            end
        end
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            return;
        end
        check("bvalid_pre_commit", s_bvalid, 0);
        exp_resp = model_wresp(addr);
        step();
        model_write(addr, data, strb);
        check("bvalid_commit", s_bvalid, 1);
        check("bresp", s_bresp, exp_resp);
        check("wr_pulse", wr_pulse, onehot_if(exp_resp == 2'b00, addr));
        check("reg_out_after_write", reg_out, model_vec());
        for (int i = 0; i < bdelay; i++) begin
            step();
            check("bp_bvalid", s_bvalid, 1);
            check("bp_bresp", s_bresp, exp_resp);
            check("bp_readies", {s_awready, s_wready}, 2'b00);
            check("wr_pulse_one_cycle", wr_pulse, 0);
        end
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;
        check("bvalid_cleared", s_bvalid, 0);
        check("readies_after_b", {s_awready, s_wready}, 2'b11);
        check("wr_pulse_idle", wr_pulse, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdelay);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = model_rdata(addr);
        exp_resp = (addr >= 32'(4*N)) ? 2'b11 : 2'b00;
        s_araddr = addr;
        s_arvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        check("ar_handshake", ar_hs, 1);
        check("rvalid", s_rvalid, 1);
        check("rdata", s_rdata, exp_data);
        check("rresp", s_rresp, exp_resp);
        check("rd_pulse", rd_pulse, onehot_if(exp_resp == 2'b00, addr));
        for (int i = 0; i < rdelay; i++) begin
            step();
            check("bp_rvalid", s_rvalid, 1);
            check("bp_rdata", {s_rresp, s_rdata}, {exp_resp, exp_data});
            check("bp_arready", s_arready, 0);
            check("rd_pulse_one_cycle", rd_pulse, 0);
        end
        s_rready = 1'b1;
        step();
        s_rready = 1'b0;
        check("rvalid_cleared", s_rvalid, 0);
        check("arready_after_r", s_arready, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready_valid"},
              {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 5'b0);
        check({tag, "_resp_data"}, {s_bresp, s_rresp, s_rdata}, 0);
        check({tag, "_pulses"}, {wr_pulse, rd_pulse}, 0);
        check({tag, "_reg_out"}, reg_out, 0);
    endtask

    initial begin
        logic [31:0] old_val;
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        status_in = '0;
        status_in[15*32 +: 32] = 32'h0000CAFE;
        for (int i = 0; i < N; i++) model_regs[i] = '0;

        step(); step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Basic write/read at 0x04.
        do_write(32'h04, 32'hDEADBEEF, 4'b1111, 0, 0);
        check("reg1_value", reg_out[63:32], 32'hDEADBEEF);
        do_read(32'h04, 0);

        // W leads AW by three cycles, partial strobe.
        do_write(32'h08, 32'hAAAAAAAA, 4'b1111, 0, 0);
        do_write(32'h08, 32'h11223344, 4'b0101, 3, 0);
        check("reg2_strobe_merge", reg_out[95:64], 32'hAA22AA44);

        // Read-only status register.
        do_read(32'h3C, 0);
        do_write(32'h3C, 32'h12345678, 4'b1111, 0, 0);
        do_read(32'h3C, 0);

        // Unmapped address.
        do_write(32'h40, 32'hFFFFFFFF, 4'b1111, -2, 0);
        do_read(32'h40, 0);

        // Backpressure on both response channels.
        do_write(32'h10, 32'h0BADF00D, 4'b1111, 0, 5);
        do_read(32'h10, 5);

        // Read collides with write commit: old value returned.
        old_val = model_regs[3];
        s_awaddr = 32'h0C; s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 32'h0C; s_arvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        model_write(32'h0C, 32'h5A5A5A5A, 4'hF);
        check("collide_rdata_old", s_rdata, old_val);
        check("collide_valids", {s_bvalid, s_rvalid}, 2'b11);
        check("collide_pulses", {wr_pulse, rd_pulse}, {16'h0008, 16'h0008});
        check("collide_reg_new", reg_out, model_vec());
        s_bready = 1'b1; s_rready = 1'b1;
        step();
        s_bready = 1'b0; s_rready = 1'b0;
        check("collide_done", {s_bvalid, s_rvalid}, 2'b00);

        // Reset while AW is held and a read response is pending.
        s_awaddr = 32'h00; s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        s_araddr = 32'h04; s_arvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        check("pre_reset_rvalid", s_rvalid, 1);
        rst_n = 1'b0;
        step();
        check_all_zero("midreset");
        for (int i = 0; i < N; i++) model_regs[i] = '0;
        rst_n = 1'b1;
        step();
        s_wdata = 32'h01020304; s_wstrb = 4'hF; s_wvalid = 1'b1;
        step();
        s_wvalid = 1'b0;
        check("lone_w_accepted", w_hs, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lone_w_no_commit", {s_bvalid, wr_pulse}, 0);
        end
        s_awaddr = 32'h18; s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        step();
        model_write(32'h18, 32'h01020304, 4'hF);
        check("late_aw_commit", {s_bvalid, s_bresp, wr_pulse}, {1'b1, 2'b00, 16'h0040});
        check("late_aw_reg", reg_out, model_vec());
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000_0000)
                                               : (($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
            status_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
            else
                do_read(addr, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
